// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: bypass-select width and forwarding-code encoding.
// Code 0 selects the register file; code s+1 selects the result held in tracked stage s.
package mips_pipe_pkg;

    localparam int FWD_GRF = 0;

    typedef enum logic {
        USE_E = 1'b0,
        USE_D = 1'b1
    } use_stage_e;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic int fwd_stage(input int s);
        return s + 1;
    endfunction

endpackage

// File: rtl/hazard_sb_match.sv
// Per-source hazard check: finds the youngest in-flight writer of one source register
// and decides whether it can be bypassed now, must stall, or needs an E-stage bypass later.
module hazard_sb_match
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int RW     = 2,
    parameter int SELW   = 3
) (
    input  logic [DEPTH-1:0]        ent_valid,
    input  logic [DEPTH-1:0]        ent_wen,
    input  logic [DEPTH*ADDR_W-1:0] ent_dst,
    input  logic [DEPTH*RW-1:0]     ent_r,
    input  logic [ADDR_W-1:0]       src,
    input  logic                    early,
    output logic                    stall,
    output logic [SELW-1:0]         fwd_d,
    output logic [SELW-1:0]         fwd_e_next
);

    use_stage_e      use_st;
    logic            hit;
    logic [SELW-1:0] hit_s;
    logic [RW-1:0]   hit_r;
    logic            fwdable;

    assign use_st = use_stage_e'(early);

    // Scan oldest to youngest so the lowest matching stage is what remains.
    always_comb begin
        hit   = 1'b0;
        hit_s = '0;
        hit_r = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (ent_valid[s] && ent_wen[s] && (src != '0) &&
                (ent_dst[s*ADDR_W +: ADDR_W] == src)) begin
                hit   = 1'b1;
                hit_s = SELW'(s);
                hit_r = ent_r[s*RW +: RW];
            end
        end
    end

    // The last stage writes the GRF this cycle and the GRF writes through to D reads.
    always_comb begin
        fwdable    = 1'b1;
        fwd_d      = SELW'(FWD_GRF);
        fwd_e_next = SELW'(FWD_GRF);
        if (hit && (hit_s != SELW'(DEPTH - 1))) begin
            if (use_st == USE_D) begin
                fwdable = (hit_s > SELW'(hit_r));
                if (fwdable) begin
                    fwd_d = SELW'(fwd_stage(int'(hit_s)));
                end
            end else begin
                fwdable    = (hit_s >= SELW'(hit_r));
                fwd_e_next = SELW'(fwd_stage(int'(hit_s) + 1));
            end
        end
        stall = hit & ~fwdable;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks writers in stages E..W, raises the D-stage stall
// and produces D-stage and registered E-stage bypass selects for each source operand.
module hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    localparam int SELW  = sel_width(DEPTH),
    localparam int RW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_valid,
    input  logic [NSRC*ADDR_W-1:0] d_src,
    input  logic [NSRC-1:0]        d_src_early,
    input  logic                   d_wen,
    input  logic [ADDR_W-1:0]      d_dst,
    input  logic [RW-1:0]          d_rdy,
    input  logic                   ext_stall,
    input  logic                   flush_d,
    output logic                   stall_d,
    output logic [NSRC*SELW-1:0]   fwd_d,
    output logic [NSRC*SELW-1:0]   fwd_e,
    output logic                   e_valid,
    output logic [31:0]            stall_cnt
);

    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_wen;
    logic [DEPTH*ADDR_W-1:0] ent_dst;
    logic [DEPTH*RW-1:0]     ent_r;
    logic [NSRC-1:0]         src_stall;
    logic [NSRC*SELW-1:0]    fwd_e_next;
    logic                    insert;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_sb_match #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .RW     (RW),
            .SELW   (SELW)
        ) u_match (
            .ent_valid  (ent_valid),
            .ent_wen    (ent_wen),
            .ent_dst    (ent_dst),
            .ent_r      (ent_r),
            .src        (d_src[i*ADDR_W +: ADDR_W]),
            .early      (d_src_early[i]),
            .stall      (src_stall[i]),
            .fwd_d      (fwd_d[i*SELW +: SELW]),
            .fwd_e_next (fwd_e_next[i*SELW +: SELW])
        );
    end

    assign stall_d = d_valid & (|src_stall);
    assign insert  = d_valid & ~stall_d & ~flush_d;
    assign e_valid = ent_valid[0];

    // Entries shift one stage per unfrozen cycle; a stalled or flushed D becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            ent_wen   <= '0;
            ent_dst   <= '0;
            ent_r     <= '0;
            fwd_e     <= '0;
            stall_cnt <= '0;
        end else if (!ext_stall) begin
            ent_valid <= {ent_valid[DEPTH-2:0], insert};
            ent_wen   <= {ent_wen[DEPTH-2:0], insert & d_wen};
            ent_dst   <= {ent_dst[(DEPTH-1)*ADDR_W-1:0], d_dst};
            ent_r     <= {ent_r[(DEPTH-1)*RW-1:0], d_rdy};
            fwd_e     <= insert ? fwd_e_next : '0;
            if (stall_d && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=3, NSRC=2, ADDR_W=5).
// Expected values are hand-derived from the stage/ready-time rules for each scenario.
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;
    localparam int NSRC   = 2;
    localparam int SELW   = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   d_valid;
    logic [NSRC*ADDR_W-1:0] d_src;
    logic [NSRC-1:0]        d_src_early;
    logic                   d_wen;
    logic [ADDR_W-1:0]      d_dst;
    logic [1:0]             d_rdy;
    logic                   ext_stall;
    logic                   flush_d;
    logic                   stall_d;
    logic [NSRC*SELW-1:0]   fwd_d;
    logic [NSRC*SELW-1:0]   fwd_e;
    logic                   e_valid;
    logic [31:0]            stall_cnt;

    int vecCount  = 0;
    int failCount = 0;

    hazard_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NSRC   (NSRC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_src       (d_src),
        .d_src_early (d_src_early),
        .d_wen       (d_wen),
        .d_dst       (d_dst),
        .d_rdy       (d_rdy),
        .ext_stall   (ext_stall),
        .flush_d     (flush_d),
        .stall_d     (stall_d),
        .fwd_d       (fwd_d),
        .fwd_e       (fwd_e),
        .e_valid     (e_valid),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one D-stage instruction, then lets combinational outputs settle.
    task automatic applyStimulus(input logic v, input int s0, input int s1,
                                 input logic e0, input logic e1,
                                 input logic wen, input int dst, input int rdy);
        d_valid     = v;
        d_src       = {ADDR_W'(s1), ADDR_W'(s0)};
        d_src_early = {e1, e0};
        d_wen       = wen;
        d_dst       = ADDR_W'(dst);
        d_rdy       = 2'(rdy);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH) tick();
    endtask

    initial begin
        reset     = 1'b1;
        ext_stall = 1'b0;
        flush_d   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_stall_d", 32'(stall_d), 0);
        checkOutput("rst_fwd_d", 32'(fwd_d), 0);
        checkOutput("rst_fwd_e", 32'(fwd_e), 0);
        checkOutput("rst_e_valid", 32'(e_valid), 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);

        // Load-use: lw $8 in E, add reads $8 in E stage.
        applyStimulus(1, 0, 0, 0, 0, 1, 8, 1);
        tick();
        checkOutput("lu_e_valid", 32'(e_valid), 1);
        applyStimulus(1, 8, 0, 0, 0, 1, 10, 0);
        checkOutput("lu_stall1", 32'(stall_d), 1);
        tick();
        checkOutput("lu_bubble", 32'(e_valid), 0);
        checkOutput("lu_stall2", 32'(stall_d), 0);
        checkOutput("lu_fwd_d", 32'(fwd_d), 0);
        tick();
        checkOutput("lu_fwd_e", 32'(fwd_e), 3);
        checkOutput("lu_cnt", stall_cnt, 1);
        drain();

        // Branch after ALU: add $9 in E, beq reads $9 early.
        applyStimulus(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        applyStimulus(1, 9, 0, 1, 0, 0, 0, 0);
        checkOutput("br_stall1", 32'(stall_d), 1);
        tick();
        checkOutput("br_stall2", 32'(stall_d), 0);
        checkOutput("br_fwd_d", 32'(fwd_d), 2);
        tick();
        checkOutput("br_fwd_e", 32'(fwd_e), 0);
        checkOutput("br_e_valid", 32'(e_valid), 1);
        checkOutput("br_cnt", stall_cnt, 2);
        drain();

        // Register zero: load-latency writers of $0 fill every stage.
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1);
        repeat (DEPTH) tick();
        applyStimulus(1, 0, 0, 0, 1, 1, 3, 0);
        checkOutput("r0_stall", 32'(stall_d), 0);
        checkOutput("r0_fwd_d", 32'(fwd_d), 0);
        tick();
        checkOutput("r0_fwd_e", 32'(fwd_e), 0);
        checkOutput("r0_cnt", stall_cnt, 2);
        drain();

        // Youngest wins: $5 written twice; src0 early, src1 E-consumed.
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
        tick();
        applyStimulus(1, 5, 5, 1, 0, 0, 0, 0);
        checkOutput("yw_stall1", 32'(stall_d), 1);
        checkOutput("yw_fwd_d1", 32'(fwd_d), 0);
        tick();
        checkOutput("yw_stall2", 32'(stall_d), 0);
        checkOutput("yw_fwd_d2", 32'(fwd_d), 2);
        tick();
        checkOutput("yw_fwd_e", 32'(fwd_e), 24);
        checkOutput("yw_cnt", stall_cnt, 3);
        drain();

        // Freeze: lw $8 reads $4 (E bypass), then add reads $8 while frozen.
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 0);
        tick();
        applyStimulus(1, 4, 0, 0, 0, 1, 8, 1);
        checkOutput("fz_lw_stall", 32'(stall_d), 0);
        tick();
        checkOutput("fz_fwd_e0", 32'(fwd_e), 2);
        ext_stall = 1'b1;
        applyStimulus(1, 8, 0, 0, 0, 1, 10, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("fz_stall_%0d", k), 32'(stall_d), 1);
            checkOutput($sformatf("fz_e_valid_%0d", k), 32'(e_valid), 1);
            checkOutput($sformatf("fz_fwd_e_%0d", k), 32'(fwd_e), 2);
            checkOutput($sformatf("fz_cnt_%0d", k), stall_cnt, 3);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("fzr_e_valid", 32'(e_valid), 0);
        checkOutput("fzr_cnt", stall_cnt, 0);
        checkOutput("fzr_fwd_e", 32'(fwd_e), 0);
        checkOutput("fzr_stall", 32'(stall_d), 0);
        ext_stall = 1'b0;
        drain();

        // Flush: a killed writer of $7 must never be seen by a later reader.
        flush_d = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0);
        tick();
        flush_d = 1'b0;
        checkOutput("fl_e_valid", 32'(e_valid), 0);
        applyStimulus(1, 7, 7, 1, 0, 0, 0, 0);
        checkOutput("fl_stall", 32'(stall_d), 0);
        checkOutput("fl_fwd_d", 32'(fwd_d), 0);
        tick();
        checkOutput("fl_fwd_e", 32'(fwd_e), 0);
        checkOutput("fl_cnt", stall_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
